// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs loads/stores over a req/ack data bus and stalls the front end while busy.
// Optional macro MEM_STAGE_TIMEOUT_EN aborts an access that sees no dmem_ack within TIMEOUT_CYCLES.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EXMEM_AluRES,
  input  logic [31:0] EXMEM_StoreData,
  input  logic [2:0]  EXMEM_Funct3,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic [4:0]  EXMEM_rd,
  input  logic        EXMEM_WriteBack,
  output logic [31:0] MEM_LoadData,
  output logic [31:0] MEM_AluRES,
  output logic [4:0]  MEM_rd,
  output logic        MEM_WriteBack,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        mem_op, is_load, is_store, misaligned, start, timeout;
  logic [1:0]  off;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, lane, ld_ext, load_q;

  if (TIMEOUT_CYCLES >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold TIMEOUT_CYCLES");
  end

  // A load+store encoding is treated as a plain load.
  always_comb begin
    off      = EXMEM_AluRES[1:0];
    mem_op   = EXMEM_MemRead | EXMEM_MemWrite;
    is_load  = EXMEM_MemRead;
    is_store = EXMEM_MemWrite & ~EXMEM_MemRead;
    if (EXMEM_Funct3[1])      misaligned = (off != 2'b00);
    else if (EXMEM_Funct3[0]) misaligned = off[0];
    else                      misaligned = 1'b0;
    start = (state == IDLE) && mem_op && !misaligned;
  end

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = EXMEM_StoreData;
    case (EXMEM_Funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << off;
        st_wdata = {4{EXMEM_StoreData[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << off;
        st_wdata = {2{EXMEM_StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Word loads are always aligned, so the shifted lane equals the raw word for them.
  always_comb begin
    lane = dmem_rdata >> {off, 3'b000};
    case (EXMEM_Funct3)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  assign timeout = (state == ACCESS) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= timeout;
      if (start)                             cnt <= '0;
      else if (state == ACCESS && !dmem_ack) cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_fault = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    MEM_AluRES    = EXMEM_AluRES;
    MEM_rd        = EXMEM_rd;
    MEM_WriteBack = EXMEM_WriteBack;
    MEM_LoadData  = '0;
    mem_stall     = 1'b0;
    mem_misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && misaligned) begin
          mem_misalign  = 1'b1;
          MEM_WriteBack = 1'b0;
        end else if (mem_op) begin
          mem_stall     = 1'b1;
          MEM_WriteBack = 1'b0;
          MEM_rd        = '0;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        mem_stall     = 1'b1;
        MEM_WriteBack = 1'b0;
        MEM_rd        = '0;
        if (dmem_ack || timeout) state_nxt = DONE;
      end
      DONE: begin
        MEM_LoadData  = load_q;
        MEM_WriteBack = EXMEM_WriteBack & ~mem_fault;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      load_q     <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {EXMEM_AluRES[31:2], 2'b00};
        dmem_wdata <= is_store ? st_wdata : '0;
        dmem_wstrb <= is_store ? st_wstrb : '0;
      end else if (state == ACCESS && (dmem_ack || timeout)) begin
        dmem_req <= 1'b0;
        load_q   <= (is_load && !timeout) ? ld_ext : '0;
      end
    end
  end

endmodule
